// File: rtl/bus_demux3.sv
// bus_demux3: routes one core load/store request to one of three targets by address decode,
// forwards it with a valid/ready handshake and returns that target's response.
// Unmapped addresses get an error response.
// Optional feature macro: DEMUX_TIMEOUT_EN (a stalled target forces an error after TIMEOUT cycles).
module bus_demux3 #(
  parameter logic [31:0] T0_BASE = 32'h0000_0000,
  parameter logic [31:0] T0_MASK = 32'hF000_0000,
  parameter logic [31:0] T1_BASE = 32'h1000_0000,
  parameter logic [31:0] T1_MASK = 32'hF000_0000,
  parameter logic [31:0] T2_BASE = 32'h2000_0000,
  parameter logic [31:0] T2_MASK = 32'hF000_0000,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] t_addr,
  output logic        t_we,
  output logic [31:0] t_wdata,
  output logic [3:0]  t_wstrb,
  output logic [2:0]  t_valid,
  input  logic [2:0]  t_ready,
  input  logic [2:0]  t_rvalid,
  input  logic [95:0] t_rdata
);

  // StPulse is the response-pulse cycle; it keeps req_ready low until the pulse is over.
  typedef enum logic [2:0] {StIdle, StReq, StResp, StErr, StPulse} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  sel_q, sel_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic [1:0]  sel_dec;
  logic        sel_ready, sel_rvalid;
  logic [31:0] sel_rdata;
  logic        accept;
  logic        expired;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  // Priority address decode; 2'b11 means no target matched.
  always_comb begin
    sel_dec = 2'b11;
    if ((req_addr & T0_MASK) == T0_BASE)      sel_dec = 2'b00;
    else if ((req_addr & T1_MASK) == T1_BASE) sel_dec = 2'b01;
    else if ((req_addr & T2_MASK) == T2_BASE) sel_dec = 2'b10;
  end

  // Pick the handshake and response signals of the latched target.
  always_comb begin
    sel_ready  = 1'b0;
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    case (sel_q)
      2'b00: begin
        sel_ready  = t_ready[0];
        sel_rvalid = t_rvalid[0];
        sel_rdata  = t_rdata[31:0];
      end
      2'b01: begin
        sel_ready  = t_ready[1];
        sel_rvalid = t_rvalid[1];
        sel_rdata  = t_rdata[63:32];
      end
      2'b10: begin
        sel_ready  = t_ready[2];
        sel_rvalid = t_rvalid[2];
        sel_rdata  = t_rdata[95:64];
      end
      default: ;
    endcase
  end

`ifdef DEMUX_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign expired = (cnt_q == 16'(TIMEOUT - 1));

  // Wait counter: cleared on accept, counts every cycle spent waiting on the target.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = '0;
    else if (state_q == StReq || state_q == StResp) cnt_d = cnt_q + 16'd1;
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;

  assign expired        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Next-state and response logic; completion is checked before expiry so it wins a tie.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    sel_d        = sel_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          sel_d   = sel_dec;
          state_d = (sel_dec == 2'b11) ? StErr : StReq;
        end
      end
      StReq: begin
        if (sel_ready)    state_d = StResp;
        else if (expired) state_d = StErr;
      end
      StResp: begin
        if (sel_rvalid) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? 32'h0 : sel_rdata;
          state_d      = StPulse;
        end else if (expired) begin
          state_d = StErr;
        end
      end
      StErr: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        resp_rdata_d = '0;
        state_d      = StPulse;
      end
      StPulse: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and latched request/response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      sel_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      sel_q        <= sel_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign t_valid    = (state_q == StReq) ? (3'b001 << sel_q) : 3'b000;
  assign t_addr     = addr_q;
  assign t_we       = we_q;
  assign t_wdata    = wdata_q;
  assign t_wstrb    = wstrb_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_bus_demux3.sv
// Testbench for bus_demux3: directed vector table, randomized transactions against a
// transaction-level model, and hand-written reset/timeout sequences.
module tb_bus_demux3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] t_addr;
  logic        t_we;
  logic [31:0] t_wdata;
  logic [3:0]  t_wstrb;
  logic [2:0]  t_valid;
  logic [2:0]  t_ready;
  logic [2:0]  t_rvalid;
  logic [95:0] t_rdata;

  int checks = 0;
  int errors = 0;

  bus_demux3 dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .t_addr    (t_addr),
    .t_we      (t_we),
    .t_wdata   (t_wdata),
    .t_wstrb   (t_wstrb),
    .t_valid   (t_valid),
    .t_ready   (t_ready),
    .t_rvalid  (t_rvalid),
    .t_rdata   (t_rdata)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Address map as the model sees it: first matching window wins, -1 if none.
  function automatic int model_sel(logic [31:0] a);
    logic [31:0] bases [3];
    logic [31:0] masks [3];
    bases = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000};
    masks = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
    for (int i = 0; i < 3; i++) if ((a & masks[i]) == bases[i]) return i;
    return -1;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          rdly;
    int          vdly;
    logic [31:0] rd;
    bit          spur;
    logic [2:0]  exp_tv;
    int          exp_held;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  // One request; the bench plays every target, answering when it sees its own t_valid.
  task automatic run_txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] ws, input int rdly, input int vdly,
                         input logic [31:0] rd, input bit spur,
                         output logic [2:0] tv, output int held, output bit stable,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int pulses, output logic rdy_at, output logic rdy_after);
    bit         hs_done = 0;
    bit         rv_done = 0;
    logic [2:0] hs_tgt = 3'b000;
    int         wcnt = 0;
    int         rcnt = 0;
    tv = 3'b000; held = 0; stable = 1; lat = -1; rdata = 'x; err = 1'bx;
    pulses = 0; rdy_at = 1'bx; rdy_after = 1'bx;
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd; req_wstrb = ws;
    for (int k = 1; k < 300; k++) begin
      @(negedge clk);
      if (t_valid != 3'b000) begin
        if (tv == 3'b000) tv = t_valid;
        else if (t_valid != tv) stable = 0;
        held++;
        if (t_addr !== a || t_we !== we || t_wdata !== wd || t_wstrb !== ws) stable = 0;
      end
      if (resp_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = k; rdata = resp_rdata; err = resp_err;
        end
      end
      if (lat >= 0 && k == lat) rdy_at = req_ready;
      if (lat >= 0 && k == lat + 1) begin
        rdy_after = req_ready;
        break;
      end
      req_valid = 1'b0;
      t_ready   = 3'b000;
      t_rdata   = {$urandom, $urandom, $urandom};
      t_rvalid  = spur ? (3'($urandom) & ~t_valid & ~hs_tgt) : 3'b000;
      if (hs_done && !rv_done) begin
        if (rcnt >= vdly) begin
          t_rvalid = t_rvalid | hs_tgt;
          for (int i = 0; i < 3; i++) if (hs_tgt[i]) t_rdata[32*i +: 32] = rd;
          rv_done = 1;
        end else rcnt++;
      end else if (!hs_done && t_valid != 3'b000) begin
        if (wcnt >= rdly) begin
          t_ready = t_valid; hs_done = 1; hs_tgt = t_valid;
        end else wcnt++;
      end
    end
    req_valid = 1'b0; t_ready = 3'b000; t_rvalid = 3'b000;
  endtask

  task automatic check_txn(string tag, vec_t v);
    logic [2:0] tv; int held; bit stable; int lat; logic [31:0] rdata; logic err;
    int pulses; logic rdy_at, rdy_after;
    run_txn(v.addr, v.we, v.wdata, v.wstrb, v.rdly, v.vdly, v.rd, v.spur,
            tv, held, stable, lat, rdata, err, pulses, rdy_at, rdy_after);
    chk({tag, " t_valid"}, 32'(tv), 32'(v.exp_tv));
    chk({tag, " held"}, 32'(held), 32'(v.exp_held));
    chk({tag, " stable"}, 32'(stable), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " rdata"}, rdata, v.exp_rdata);
    chk({tag, " err"}, 32'(err), 32'(v.exp_err));
    chk({tag, " pulses"}, 32'(pulses), 32'd1);
    chk({tag, " ready_pulse"}, 32'(rdy_at), 32'd0);
    chk({tag, " ready_after"}, 32'(rdy_after), 32'd1);
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, " resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, " resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, " t_valid"}, 32'(t_valid), 32'd0);
    chk({tag, " t_addr"}, t_addr, 32'd0);
    chk({tag, " t_fields"}, {t_wdata[30:0], t_we}, 32'd0);
    chk({tag, " t_wstrb"}, 32'(t_wstrb), 32'd0);
  endtask

  vec_t vecs [7];

  initial begin
    vec_t v;
    int   cnt;
    bit   got;

    vecs[0] = '{32'h0000_0010, 1'b0, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 1'b0,
                3'b001, 1, 3, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{32'h1000_0004, 1'b1, 32'h1234_5678, 4'b0011, 3, 0, 32'hAAAA_5555, 1'b0,
                3'b010, 4, 6, 32'h0, 1'b0};
    vecs[2] = '{32'h5000_0000, 1'b0, 32'h0, 4'h0, 0, 0, 32'h1111_1111, 1'b1,
                3'b000, 0, 2, 32'h0, 1'b1};
    vecs[3] = '{32'h2000_0100, 1'b0, 32'h0, 4'hF, 0, 2, 32'hCAFE_0001, 1'b1,
                3'b100, 1, 5, 32'hCAFE_0001, 1'b0};
    vecs[4] = '{32'h0FFF_FFFC, 1'b1, 32'hA5A5_A5A5, 4'b1000, 1, 1, 32'h7777_7777, 1'b1,
                3'b001, 2, 5, 32'h0, 1'b0};
    vecs[5] = '{32'hF000_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 0, 32'h0, 1'b0,
                3'b000, 0, 2, 32'h0, 1'b1};
    vecs[6] = '{32'h1FFF_FFFF, 1'b0, 32'h0, 4'h0, 2, 3, 32'h0BAD_F00D, 1'b1,
                3'b010, 3, 8, 32'h0BAD_F00D, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0;
    req_wstrb = '0; t_ready = '0; t_rvalid = '0; t_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");

    foreach (vecs[i]) check_txn($sformatf("vec%0d", i), vecs[i]);

    // Randomized transactions; expectations come from the address map and timing rules.
    for (int n = 0; n < 60; n++) begin
      int s;
      logic [3:0] hi;
      hi = 4'($urandom_range(0, 15));
      v.addr  = {hi, 28'($urandom)};
      v.we    = 1'($urandom);
      v.wdata = $urandom;
      v.wstrb = 4'($urandom);
      v.rdly  = $urandom_range(0, 4);
      v.vdly  = $urandom_range(0, 4);
      v.rd    = $urandom;
      v.spur  = 1'($urandom);
      s = model_sel(v.addr);
      if (s < 0) begin
        v.exp_tv = 3'b000; v.exp_held = 0; v.exp_lat = 2; v.exp_rdata = 0; v.exp_err = 1'b1;
      end else begin
        v.exp_tv    = 3'(1 << s);
        v.exp_held  = v.rdly + 1;
        v.exp_lat   = 3 + v.rdly + v.vdly;
        v.exp_rdata = v.we ? 32'h0 : v.rd;
        v.exp_err   = 1'b0;
      end
      check_txn($sformatf("rand%0d", n), v);
    end

    // Reset while waiting in RESP: no response, late t_rvalid ignored.
    req_valid = 1'b1; req_addr = 32'h0000_0040; req_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; t_ready = 3'b001;
    @(negedge clk);
    t_ready = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("midreset");
    t_rvalid = 3'b001; t_rdata = {3{32'h5555_AAAA}};
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      t_rvalid = 3'b000;
      if (resp_valid) cnt++;
    end
    chk("midreset no_resp", 32'(cnt), 32'd0);
    chk("midreset idle", 32'(req_ready), 32'd1);

    // Target 0 accepts but never answers.
    req_valid = 1'b1; req_addr = 32'h0000_0000; req_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; t_ready = 3'b001;
    @(negedge clk);
    t_ready = 3'b000;
    got = 0; cnt = 0;
`ifdef DEMUX_TIMEOUT_EN
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1;
        chk("timeout err", 32'(resp_err), 32'd1);
        chk("timeout rdata", resp_rdata, 32'd0);
      end
    end
    chk("timeout response", 32'(got), 32'd1);
    @(negedge clk);
    chk("timeout idle", 32'(req_ready), 32'd1);
`else
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    chk("stall no_resp", 32'(cnt), 32'd0);
    chk("stall busy", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("stall recovered", 32'(req_ready), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
